// File: rtl/denise_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : denise_bus_pkg
// Purpose  : Shared types and constants for the Denise register-bus driver.
// Revision : 1.0 - initial release
// ============================================================================
package denise_bus_pkg;

  localparam logic [8:1] RGA_IDLE = 8'hFF;

  typedef struct packed {
    logic       write;
    logic [8:1] addr;
    logic [15:0] wdata;
  } rga_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WSLOT = 2'd1,
    RSLOT = 2'd2
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/rga_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rga_req_fifo
// Purpose  : Two-entry request FIFO with a registered ready flag.
// Revision : 1.0 - initial release
// ============================================================================
module rga_req_fifo
  import denise_bus_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  rga_req_t push_data,
  output logic     ready,
  input  logic     pop,
  output rga_req_t head,
  output logic     empty
);

  rga_req_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && (count != 2'd0);

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // ready looks at the post-update count, so a full FIFO popping this clk
  // still reports not-ready until the next clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      ready  <= 1'b0;
    end else begin
      count <= count_next;
      ready <= (count_next != 2'd2);
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/rga_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : rga_bus_driver
// Purpose  : Issues queued register accesses as CCK-aligned RGA bus slots.
//            Read slots exist only when RGA_DRV_READBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rga_bus_driver
  import denise_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cck,
  input  logic        cck_edge,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [8:1]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [8:1]  rga,
  output logic [15:0] db_out,
  output logic        db_oen,
  input  logic [15:0] db_in,
  output logic        busy
);

  slot_state_t state;
  slot_state_t state_next;
  rga_req_t    head;
  rga_req_t    push_data;
  logic        fifo_empty;
  logic        rise;
  logic        fall;
  logic        pop;
  logic [8:1]  rga_next;
  logic [15:0] db_out_next;
  logic        db_oen_next;

  assign rise      = cck_edge && cck;
  assign fall      = cck_edge && !cck;
  assign pop       = rise && !fifo_empty;
  assign push_data = '{write: req_write, addr: req_addr, wdata: req_wdata};

  rga_req_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (push_data),
    .ready     (req_ready),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (rise) begin
      if (fifo_empty)      state_next = IDLE;
      else if (head.write) state_next = WSLOT;
`ifdef RGA_DRV_READBACK_EN
      else                 state_next = RSLOT;
`else
      else                 state_next = IDLE;
`endif
    end
  end

  always_comb begin
    rga_next    = rga;
    db_out_next = db_out;
    db_oen_next = db_oen;
    if (rise) begin
      db_oen_next = 1'b0;
      case (state_next)
        WSLOT: begin
          rga_next    = head.addr;
          db_out_next = head.wdata;
        end
        RSLOT: begin
          rga_next    = head.addr;
          db_out_next = 16'h0000;
        end
        default: begin
          rga_next    = RGA_IDLE;
          db_out_next = 16'h0000;
        end
      endcase
    end else if (fall && state == WSLOT) begin
      db_oen_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rga    <= RGA_IDLE;
      db_out <= 16'h0000;
      db_oen <= 1'b0;
    end else begin
      rga    <= rga_next;
      db_out <= db_out_next;
      db_oen <= db_oen_next;
    end
  end

`ifdef RGA_DRV_READBACK_EN
  // The closing rising edge of a read slot is where the chip's data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
    end else begin
      rsp_valid <= rise && (state == RSLOT);
      if (rise && (state == RSLOT)) rsp_rdata <= db_in;
    end
  end
`else
  logic unused_db_in;
  assign unused_db_in = ^db_in;
  assign rsp_valid    = 1'b0;
  assign rsp_rdata    = 16'h0000;
`endif

  assign busy = !rst && (!fifo_empty || (state != IDLE));

endmodule
`default_nettype wire
